// File: rtl/fp_pkg.sv
// Shared constants, field widths and FSM state encoding for the FP subtractor.
package fp_pkg;
  localparam int SIGN_W = 1;
  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int MANT_W = FRAC_W + 1;
  localparam int EXP_BIAS = 127;
  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [2:0] {IDLE, ALIGN, OP, NORM, DONE} state_t;
endpackage

// File: rtl/fp_unpack.sv
// Splits an IEEE-754 single into sign, exponent and mantissa with hidden bit.
// The hidden bit is clear for exponent 0; the raw fraction is still passed so
// the consumer decides how to treat denormals.
module fp_unpack
  import fp_pkg::*;
(
  input  logic [31:0]       word,
  output logic              sign,
  output logic [EXP_W-1:0]  expo,
  output logic [MANT_W-1:0] mant,
  output logic              is_zero,
  output logic              is_special
);
  assign sign       = word[31];
  assign expo       = word[30:23];
  assign is_zero    = (expo == '0);
  assign is_special = (expo == EXP_MAX);
  assign mant       = {~is_zero, word[FRAC_W-1:0]};
endmodule

// File: rtl/fp_sub_seq.sv
// Multi-cycle IEEE-754 single subtractor (a - b), truncating, denormals
// flushed. Serial alignment and normalisation, one bit per cycle.
module fp_sub_seq
  import fp_pkg::*;
#(
  parameter int ALIGN_CAP = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] result,
  output logic        out_valid,
  input  logic        out_ready
);
  localparam logic [EXP_W-1:0] CAP = EXP_W'(ALIGN_CAP);

  logic              sa, sb, za, zb, spa, spb;
  logic [EXP_W-1:0]  ea, eb;
  logic [MANT_W-1:0] ma_raw, mb_raw;

  fp_unpack u_unpack_a (.word(a), .sign(sa), .expo(ea), .mant(ma_raw),
                        .is_zero(za), .is_special(spa));
  fp_unpack u_unpack_b (.word(b), .sign(sb), .expo(eb), .mant(mb_raw),
                        .is_zero(zb), .is_special(spb));

  // Operand ordering and shift count, evaluated on the accept cycle
  logic [MANT_W-1:0] ma, mb, mx, my;
  logic [EXP_W-1:0]  ex, ey, diff, cnt_ld;
  logic              a_ge, sign_x;

  // Denormal fractions are discarded so a zero exponent means zero magnitude
  assign ma     = za ? '0 : ma_raw;
  assign mb     = zb ? '0 : mb_raw;
  assign a_ge   = {ea, ma} >= {eb, mb};
  assign ex     = a_ge ? ea : eb;
  assign ey     = a_ge ? eb : ea;
  assign mx     = a_ge ? ma : mb;
  assign my     = a_ge ? mb : ma;
  assign sign_x = a_ge ? sa : ~sb;
  assign diff   = ex - ey;
  assign cnt_ld = (diff > CAP) ? CAP : diff;

  state_t            state, state_nx;
  logic              sign_r, sub_r, nan_r;
  logic [EXP_W-1:0]  exp_r, cnt_r;
  logic [MANT_W-1:0] mx_r, my_r;
  logic [MANT_W:0]   sum_r;
  logic [31:0]       result_r;
  logic              need_l;

  // Left shift wanted: no carry, leading bit clear, something left to normalise
  assign need_l = ~sum_r[MANT_W] & ~sum_r[MANT_W-1] & (sum_r != '0);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic; NaN operands skip straight to NORM to pack the QNAN
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (in_valid) state_nx = (spa | spb) ? NORM : ALIGN;
      ALIGN: if (cnt_r == '0) state_nx = OP;
      OP:    state_nx = NORM;
      NORM: begin
        if (nan_r)                        state_nx = DONE;
        else if (sum_r[MANT_W])           state_nx = NORM;
        else if (need_l && exp_r > 8'd1)  state_nx = NORM;
        else                              state_nx = DONE;
      end
      DONE:  if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: capture, align, add/sub, normalise and pack
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_r   <= 1'b0;
      sub_r    <= 1'b0;
      nan_r    <= 1'b0;
      exp_r    <= '0;
      cnt_r    <= '0;
      mx_r     <= '0;
      my_r     <= '0;
      sum_r    <= '0;
      result_r <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          nan_r <= spa | spb;
          if (spa | spb) begin
            sum_r <= '0;
          end else begin
            sign_r <= sign_x;
            sub_r  <= (sa == sb);
            exp_r  <= ex;
            mx_r   <= mx;
            my_r   <= my;
            cnt_r  <= cnt_ld;
          end
        end
        ALIGN: if (cnt_r != '0) begin
          my_r  <= my_r >> 1;
          cnt_r <= cnt_r - 1'b1;
        end
        OP: sum_r <= sub_r ? ({1'b0, mx_r} - {1'b0, my_r})
                           : ({1'b0, mx_r} + {1'b0, my_r});
        NORM: begin
          if (nan_r) begin
            result_r <= QNAN;
          end else if (sum_r[MANT_W]) begin
            sum_r <= sum_r >> 1;
            exp_r <= exp_r + 1'b1;
          end else if (need_l) begin
            // Exponent cannot go below 1: flush instead of shifting
            if (exp_r <= 8'd1) result_r <= '0;
            else begin
              sum_r <= sum_r << 1;
              exp_r <= exp_r - 1'b1;
            end
          end else if (sum_r == '0) begin
            result_r <= '0;
          end else if (exp_r == EXP_MAX) begin
            result_r <= {sign_r, EXP_MAX, {FRAC_W{1'b0}}};
          end else begin
            result_r <= {sign_r, exp_r, sum_r[FRAC_W-1:0]};
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign result    = result_r;
endmodule

// File: tb/tb_fp_sub_seq.sv
// Randomised and directed bench for fp_sub_seq with a behavioural model.
module tb_fp_sub_seq;
  localparam int CAP = 24;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic        in_valid = 1'b0, out_ready = 1'b0;
  logic        in_ready, out_valid;
  logic [31:0] result;

  int n_tests = 0;
  int n_fail  = 0;

  fp_sub_seq #(.ALIGN_CAP(CAP)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .in_valid(in_valid),
    .in_ready(in_ready), .result(result), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  // Reference: real-number style subtraction with truncation and the
  // cycle cost of each serial step.
  function automatic void model(input logic [31:0] fa, input logic [31:0] fb,
                                output logic [31:0] r, output int lat);
    int ea, eb, ex, ey, cnt, e, k;
    int unsigned ma, mb, mx, my, v;
    bit sa, sb, sx, uf;
    ea = int'(fa[30:23]);
    eb = int'(fb[30:23]);
    if (ea == 255 || eb == 255) begin
      r = 32'h7FC0_0000; lat = 1; return;
    end
    ma = (ea == 0) ? 0 : (32'h80_0000 | 32'(fa[22:0]));
    mb = (eb == 0) ? 0 : (32'h80_0000 | 32'(fb[22:0]));
    sa = fa[31];
    sb = !fb[31];
    if (ea > eb || (ea == eb && ma >= mb)) begin
      ex = ea; mx = ma; sx = sa; ey = eb; my = mb;
    end else begin
      ex = eb; mx = mb; sx = sb; ey = ea; my = ma;
    end
    cnt = ex - ey;
    if (cnt > CAP) cnt = CAP;
    my = my >> cnt;
    v  = (sa == sb) ? mx + my : mx - my;
    e = ex; k = 0; uf = 0; r = '0;
    if (v != 0) begin
      if (v >= 32'h100_0000) begin v = v >> 1; e++; k = 1; end
      while (v < 32'h80_0000 && !uf) begin
        if (e == 1) uf = 1;
        else begin v = v << 1; e--; k++; end
      end
      if (uf)            r = '0;
      else if (e == 255) r = {sx, 8'hFF, 23'h0};
      else               r = {sx, e[7:0], v[22:0]};
    end
    lat = cnt + 3 + k;
  endfunction

  // One transaction: accept, wait for out_valid, stall, then hand off
  task automatic do_op(input logic [31:0] ta, input logic [31:0] tb2,
                       input logic [31:0] er, input int elat, input int stall);
    int n;
    bit got;
    logic [31:0] held;
    @(negedge clk);
    a = ta; b = tb2; in_valid = 1'b1;
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'($urandom_range(0, 1)); a = $urandom; b = $urandom;
    n = 0; got = 0;
    while (!got && n < 200) begin
      @(posedge clk); n++; #1;
      if (out_valid) got = 1;
      else begin in_valid = 1'($urandom_range(0, 1)); a = $urandom; b = $urandom; end
    end
    if (!got) begin
      chk("timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
      return;
    end
    chk("latency", 32'(n), 32'(elat));
    chk("result", result, er);
    held = result;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      chk("hold_result", result, held);
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_inrdy", 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b0;
    chk("back_idle", {30'd0, in_ready, out_valid}, 32'd2);
  endtask

  function automatic logic [31:0] rnd_fp();
    int m;
    logic [7:0] e;
    m = int'($urandom_range(0, 19));
    if (m == 0)      e = 8'd0;
    else if (m == 1) e = 8'hFF;
    else if (m < 4)  e = 8'($urandom_range(250, 254));
    else if (m < 7)  e = 8'($urandom_range(1, 254));
    else if (m < 9)  e = 8'($urandom_range(1, 4));
    else             e = 8'($urandom_range(120, 134));
    return {1'($urandom_range(0, 1)), e, 23'($urandom)};
  endfunction

  typedef struct { logic [31:0] a, b, r; int lat; } vec_t;
  vec_t dir[$];

  initial begin
    logic [31:0] ra, rb, er;
    int el;
    bit seen;
    dir = '{
      '{32'h4040_0000, 32'h3F80_0000, 32'h4000_0000, 4},   // 3 - 1
      '{32'h3F80_0000, 32'hBF80_0000, 32'h4000_0000, 4},   // 1 - (-1)
      '{32'h3F80_0000, 32'h3F40_0000, 32'h3E80_0000, 6},   // 1 - 0.75
      '{32'h3F80_0000, 32'h3F80_0000, 32'h0000_0000, 3},   // exact cancel
      '{32'h4000_0000, 32'h4040_0000, 32'hBF80_0000, 4},   // 2 - 3
      '{32'h7F80_0000, 32'h3F80_0000, 32'h7FC0_0000, 1},   // inf operand
      '{32'h3F80_0000, 32'h7FC0_0001, 32'h7FC0_0000, 1},   // nan operand
      '{32'h4B80_0000, 32'h3F80_0000, 32'h4B80_0000, 27},  // diff == cap
      '{32'h5380_0000, 32'h3F80_0000, 32'h5380_0000, 27},  // diff saturates
      '{32'h7F7F_FFFF, 32'hFF7F_FFFF, 32'h7F80_0000, 4},   // overflow
      '{32'h00C0_0000, 32'h0080_0000, 32'h0000_0000, 3},   // underflow
      '{32'h0000_0001, 32'h3F80_0000, 32'hBF80_0000, 27}   // denormal flush
    };

    #22;
    chk("rst_inrdy", 32'(in_ready), 32'd1);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_result", result, 32'd0);
    rst_n = 1'b1;

    foreach (dir[i]) do_op(dir[i].a, dir[i].b, dir[i].r, dir[i].lat, (i == 0) ? 5 : 0);

    // Reset in the middle of NORM (1 - 0.75 spends edges 3..6 there)
    @(negedge clk);
    a = 32'h3F80_0000; b = 32'h3F40_0000; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_state", {30'd0, in_ready, out_valid}, 32'd2);
    chk("midrst_result", result, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    repeat (10) begin @(posedge clk); #1 if (out_valid) seen = 1; end
    chk("midrst_no_out", 32'(seen), 32'd0);
    do_op(32'h4040_0000, 32'h3F80_0000, 32'h4000_0000, 4, 0);

    for (int t = 0; t < 150; t++) begin
      ra = rnd_fp();
      case ($urandom_range(0, 3))
        0: rb = ra ^ 32'($urandom_range(0, 255));
        1: rb = ra;
        default: rb = rnd_fp();
      endcase
      if ($urandom_range(0, 1) == 1) rb[31] = ~rb[31];
      model(ra, rb, er, el);
      do_op(ra, rb, er, el, int'($urandom_range(0, 2)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fp_sub_seq.md
FP_SUB_SEQ -- requirements
Module: fp_sub_seq

Interface
REQ-001 SHALL have parameter ALIGN_CAP, default 24, the maximum alignment shift count; larger exponent differences saturate to it.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port a, input, 32, IEEE-754 single minuend.
REQ-005 SHALL have port b, input, 32, IEEE-754 single subtrahend.
REQ-006 SHALL have port in_valid, input, 1, a/b valid.
REQ-007 SHALL have port in_ready, output, 1, high only in IDLE.
REQ-008 SHALL have port result, output, 32, a - b, registered.
REQ-009 SHALL have port out_valid, output, 1, result valid, high only in DONE.
REQ-010 SHALL have port out_ready, input, 1, consumer accepts result.

Function
REQ-011 SHALL accept operands on the edge where in_valid && in_ready, and SHALL capture a and b internally on that edge.
REQ-012 SHALL unpack each operand as sign, 8-bit exponent, 24-bit mantissa with hidden 1; exponent 0 SHALL be treated as zero (denormals flushed).
REQ-013 SHALL compute a + (-b): b sign inverted; equal effective signs -> magnitude add, else magnitude subtract.
REQ-014 SHALL at accept order the operands by magnitude ({exp,mant}); larger = X, smaller = Y; result sign = effective sign of X.
REQ-015 SHALL load the shift count min(expX - expY, ALIGN_CAP).
REQ-016 SHALL use states IDLE, ALIGN, OP, NORM, DONE; reset state IDLE.
REQ-017 ALIGN: each cycle, if count != 0, shift Y mantissa right 1 (truncate) and decrement; else go OP. ALIGN lasts count+1 cycles.
REQ-018 OP: one cycle; 25-bit sum/difference of 24-bit mantissas, exponent = expX; go NORM.
REQ-019 NORM: each cycle exactly one of: bit24 set -> shift right 1, exp+1; bit23 clear and value nonzero -> shift left 1, exp-1; else pack and go DONE.
REQ-020 SHALL flush to 0x00000000 when the magnitude is zero (including equal-magnitude subtraction) or when exp would drop below 1.
REQ-021 SHALL return signed infinity ({sign,8'hFF,23'h0}) when exp reaches 255 in NORM.
REQ-022 SHALL return 0x7FC00000 when either input has exponent 255, entering DONE on the edge after accept.
REQ-023 Latency accept-edge to out_valid high SHALL be (count+1)+1+(k+1) cycles, k = NORM shifts; no rounding (truncation).
REQ-024 DONE: result and out_valid SHALL hold stable until out_ready; on out_valid && out_ready go IDLE; no accept in the same cycle.
REQ-025 in_valid during non-IDLE states SHALL be ignored without effect.

Reset
REQ-026 SHALL on rst_n low immediately force IDLE, in_ready 1, out_valid 0, result 0x00000000, internal registers zero.
REQ-027 SHALL drop an in-flight operation on reset mid-ALIGN/OP/NORM/DONE; no output follows release.

Structure
REQ-028 SHALL take the state enum, EXP_BIAS (127), EXP_MAX (255), QNAN (0x7FC00000), and the sign/exponent/mantissa field widths from the shared package fp_pkg.
REQ-029 SHALL instantiate one sub-module fp_unpack (combinational: 32-bit word -> sign, exponent, 24-bit mantissa, is_zero, is_special), twice.

Verification
REQ-030 a=0x40400000 (3.0), b=0x3F800000 (1.0) -> result 0x40000000, out_valid 4 cycles after accept.
REQ-031 a=0x3F800000, b=0xBF800000 -> effective add -> result 0x40000000, 4 cycles.
REQ-032 a=0x3F800000, b=0x3F400000 (0.75) -> result 0x3E800000, 6 cycles; a=b=0x3F800000 -> 0x00000000, 3 cycles.
REQ-033 a=0x40000000 (2.0), b=0x40400000 (3.0) -> result 0xBF800000, 4 cycles; a=0x7F800000 -> 0x7FC00000, 1 cycle.
REQ-034 Hold out_ready low 5 cycles in DONE -> result, out_valid stable, in_ready 0; then pulse -> IDLE next edge.
REQ-035 Assert rst_n low mid-NORM -> outputs at reset values at once; after release, new accept yields correct result.
